// File: rtl/store_checker_if.sv
// Store-port bundle between the processor data-memory write port and store_checker,
// plus the checker's status and trace readout signals.
interface store_checker_if #(
   parameter int CNT_W = 16
);
   logic             en;
   logic             MemWrite;
   logic [31:0]      DataAdr;
   logic [31:0]      WriteData;
   logic             trace_rd;
   logic             done;
   logic             pass;
   logic             fail;
   logic [1:0]       fail_code;
   logic [CNT_W-1:0] cycles;
   logic [63:0]      trace_data;
   logic             trace_empty;
   logic             trace_full;
   logic             trace_ovf;

   modport master (
      output en, MemWrite, DataAdr, WriteData, trace_rd,
      input  done, pass, fail, fail_code, cycles, trace_data, trace_empty, trace_full, trace_ovf
   );

   modport slave (
      input  en, MemWrite, DataAdr, WriteData, trace_rd,
      output done, pass, fail, fail_code, cycles, trace_data, trace_empty, trace_full, trace_ovf
   );
endinterface

// File: rtl/store_checker.sv
// Sticky pass/fail monitor on the processor store port with a run-cycle counter.
// Define STORE_CHECKER_TRACE_EN to keep a FIFO trace of stores accepted in RUN.
module store_checker #(
   parameter logic [31:0] PASS_ADDR   = 32'd100,
   parameter logic [31:0] PASS_DATA   = 32'd7,
   parameter logic [31:0] ALLOW_ADDR  = 32'd96,
   parameter int          TIMEOUT     = 1000,
   parameter int          CNT_W       = 16,
   parameter int          TRACE_DEPTH = 8
) (
   input logic            clk,
   input logic            reset,
   store_checker_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] PASS = 2'd2;
   localparam logic [1:0] FAIL = 2'd3;

   localparam logic [CNT_W:0]   TIMEOUT_LAST = (CNT_W+1)'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

   logic [1:0]       state_r;
   logic [1:0]       stateNext_s;
   logic [1:0]       code_r;
   logic [1:0]       codeNext_s;
   logic [CNT_W-1:0] cycles_r;
   logic             pass_r;
   logic             fail_r;
   logic             done_r;
   logic             storeUnknown_s;
   logic             timeoutHit_s;
   logic             storeSeen_s;

   // Next-state decode: a deciding store outranks the timeout in the same cycle.
   always_comb begin
      stateNext_s    = state_r;
      codeNext_s     = code_r;
      storeSeen_s    = (bus.MemWrite == 1'b1);
      storeUnknown_s = ((^{bus.DataAdr, bus.WriteData}) === 1'bx);
      timeoutHit_s   = ({1'b0, cycles_r} == TIMEOUT_LAST);
      case (state_r)
         IDLE: begin
            if (bus.en == 1'b1) stateNext_s = RUN;
            else                stateNext_s = IDLE;
         end
         RUN: begin
            if (storeSeen_s && storeUnknown_s) begin
               stateNext_s = FAIL;
               codeNext_s  = 2'b01;
            end else if (storeSeen_s && (bus.DataAdr === PASS_ADDR) && (bus.WriteData === PASS_DATA)) begin
               stateNext_s = PASS;
               codeNext_s  = 2'b00;
            end else if (storeSeen_s && (bus.DataAdr === PASS_ADDR)) begin
               stateNext_s = FAIL;
               codeNext_s  = 2'b10;
            end else if (storeSeen_s && (bus.DataAdr !== ALLOW_ADDR)) begin
               stateNext_s = FAIL;
               codeNext_s  = 2'b01;
            end else if (timeoutHit_s) begin
               stateNext_s = FAIL;
               codeNext_s  = 2'b11;
            end else begin
               stateNext_s = RUN;
            end
         end
         PASS:    stateNext_s = PASS;
         FAIL:    stateNext_s = FAIL;
         default: stateNext_s = IDLE;
      endcase
   end

   // State, sticky flags and the saturating run counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         code_r   <= 2'b00;
         cycles_r <= {CNT_W{1'b0}};
         pass_r   <= 1'b0;
         fail_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r <= stateNext_s;
         code_r  <= codeNext_s;
         pass_r  <= (stateNext_s == PASS);
         fail_r  <= (stateNext_s == FAIL);
         done_r  <= (stateNext_s == PASS) || (stateNext_s == FAIL);
         if ((state_r == RUN) && (stateNext_s == RUN) && (cycles_r != CNT_MAX)) begin
            cycles_r <= cycles_r + CNT_ONE;
         end
      end
   end

   assign bus.done      = done_r;
   assign bus.pass      = pass_r;
   assign bus.fail      = fail_r;
   assign bus.fail_code = code_r;
   assign bus.cycles    = cycles_r;

`ifdef STORE_CHECKER_TRACE_EN
   localparam int               PTR_W   = $clog2(TRACE_DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(TRACE_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   CNT1    = {{PTR_W{1'b0}}, 1'b1};

   logic [63:0]      traceMem_r [TRACE_DEPTH];
   logic [PTR_W-1:0] wrPtr_r;
   logic [PTR_W-1:0] rdPtr_r;
   logic [PTR_W:0]   count_r;
   logic             ovf_r;
   logic             push_s;
   logic             pop_s;
   logic             full_s;
   logic             pushDo_s;

   assign push_s   = (state_r == RUN) && (bus.MemWrite == 1'b1);
   assign pop_s    = (bus.trace_rd == 1'b1) && (count_r != {(PTR_W+1){1'b0}});
   assign full_s   = (count_r == DEPTH_C);
   // A push into a full FIFO still lands when a pop frees the head in the same cycle.
   assign pushDo_s = push_s && (!full_s || pop_s);

   // Trace storage; contents are only visible through count_r so no reset is needed.
   always_ff @(posedge clk) begin
      if (pushDo_s) traceMem_r[wrPtr_r] <= {bus.DataAdr, bus.WriteData};
   end

   // FIFO pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr_r <= {PTR_W{1'b0}};
         rdPtr_r <= {PTR_W{1'b0}};
         count_r <= {(PTR_W+1){1'b0}};
         ovf_r   <= 1'b0;
      end else begin
         if (pushDo_s) wrPtr_r <= wrPtr_r + PTR_ONE;
         if (pop_s)    rdPtr_r <= rdPtr_r + PTR_ONE;
         case ({pushDo_s, pop_s})
            2'b10:   count_r <= count_r + CNT1;
            2'b01:   count_r <= count_r - CNT1;
            default: count_r <= count_r;
         endcase
         ovf_r <= ovf_r || (push_s && full_s && !pop_s);
      end
   end

   assign bus.trace_empty = (count_r == {(PTR_W+1){1'b0}});
   assign bus.trace_full  = full_s;
   assign bus.trace_ovf   = ovf_r;
   assign bus.trace_data  = (count_r != {(PTR_W+1){1'b0}}) ? traceMem_r[rdPtr_r] : 64'd0;
`else
   localparam int TRACE_DEPTH_UNUSED = TRACE_DEPTH;
   logic traceRdUnused_s;

   assign traceRdUnused_s = bus.trace_rd;
   assign bus.trace_empty = 1'b1;
   assign bus.trace_full  = 1'b0;
   assign bus.trace_ovf   = 1'b0;
   assign bus.trace_data  = 64'd0;
`endif
endmodule

// File: tb/tb_store_checker.sv
// Table-driven bench for store_checker (TIMEOUT=20, TRACE_DEPTH=2); trace expectations
// follow whether STORE_CHECKER_TRACE_EN is defined for the build.
module tb_store_checker;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   store_checker_if #(.CNT_W(16)) bus();

   store_checker #(
      .PASS_ADDR(32'd100), .PASS_DATA(32'd7), .ALLOW_ADDR(32'd96),
      .TIMEOUT(20), .CNT_W(16), .TRACE_DEPTH(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rstN, en, we;
      logic [31:0] adr, dat;
      logic        rd;
      logic        expDone, expPass, expFail;
      logic [1:0]  expCode;
      logic [15:0] expCycles;
      logic        expEmpty, expFull, expOvf;
      logic [63:0] expTrace;
   } vec_t;

   vec_t vecs[27];

   function automatic vec_t mk(logic r, logic e, logic w, logic [31:0] a, logic [31:0] d, logic rd,
                               logic dn, logic ps, logic fl, logic [1:0] c, logic [15:0] cy,
                               logic em, logic fu, logic ov, logic [63:0] td);
      vec_t v;
      v.rstN = r; v.en = e; v.we = w; v.adr = a; v.dat = d; v.rd = rd;
      v.expDone = dn; v.expPass = ps; v.expFail = fl; v.expCode = c; v.expCycles = cy;
      v.expEmpty = em; v.expFull = fu; v.expOvf = ov; v.expTrace = td;
      return v;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic r, logic e, logic w, logic [31:0] a, logic [31:0] d, logic rd);
      @(negedge clk);
      reset = r; bus.en = e; bus.MemWrite = w; bus.DataAdr = a; bus.WriteData = d; bus.trace_rd = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic checkStatus(string tag, logic dn, logic ps, logic fl, logic [1:0] c, logic [15:0] cy);
      check({tag, ".done"},      64'(bus.done),      64'(dn));
      check({tag, ".pass"},      64'(bus.pass),      64'(ps));
      check({tag, ".fail"},      64'(bus.fail),      64'(fl));
      check({tag, ".fail_code"}, 64'(bus.fail_code), 64'(c));
      check({tag, ".cycles"},    64'(bus.cycles),    64'(cy));
   endtask

   // Run from reset to RUN and idle until cycles reaches n.
   task automatic runTo(string tag, int n);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      checkStatus(tag, 1'b0, 1'b0, 1'b0, 2'b00, 16'(n));
   endtask

   initial begin
      bus.en = 1'b0; bus.MemWrite = 1'b0; bus.DataAdr = 32'd0; bus.WriteData = 32'd0; bus.trace_rd = 1'b0;

      // T1: allowed store then passing store, then drain the trace
      vecs[0]  = mk(1'b0,1'b0,1'b0,32'd0,  32'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd0, 1'b1,1'b0,1'b0,64'd0);
      vecs[1]  = mk(1'b1,1'b0,1'b0,32'd0,  32'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd0, 1'b1,1'b0,1'b0,64'd0);
      vecs[2]  = mk(1'b1,1'b1,1'b0,32'd0,  32'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd0, 1'b1,1'b0,1'b0,64'd0);
      vecs[3]  = mk(1'b1,1'b0,1'b1,32'd96, 32'd3,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd1, 1'b0,1'b0,1'b0,{32'd96,32'd3});
      vecs[4]  = mk(1'b1,1'b0,1'b1,32'd100,32'd7,1'b0, 1'b1,1'b1,1'b0,2'b00,16'd1, 1'b0,1'b1,1'b0,{32'd96,32'd3});
      vecs[5]  = mk(1'b1,1'b0,1'b0,32'd0,  32'd0,1'b1, 1'b1,1'b1,1'b0,2'b00,16'd1, 1'b0,1'b0,1'b0,{32'd100,32'd7});
      vecs[6]  = mk(1'b1,1'b0,1'b0,32'd0,  32'd0,1'b1, 1'b1,1'b1,1'b0,2'b00,16'd1, 1'b1,1'b0,1'b0,64'd0);
      vecs[7]  = mk(1'b1,1'b0,1'b0,32'd0,  32'd0,1'b1, 1'b1,1'b1,1'b0,2'b00,16'd1, 1'b1,1'b0,1'b0,64'd0);
      vecs[8]  = mk(1'b1,1'b1,1'b1,32'd64, 32'd1,1'b0, 1'b1,1'b1,1'b0,2'b00,16'd1, 1'b1,1'b0,1'b0,64'd0);
      // T2: wrong data at the pass address; later stores ignored
      vecs[9]  = mk(1'b0,1'b0,1'b0,32'd0,  32'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd0, 1'b1,1'b0,1'b0,64'd0);
      vecs[10] = mk(1'b1,1'b1,1'b0,32'd0,  32'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd0, 1'b1,1'b0,1'b0,64'd0);
      vecs[11] = mk(1'b1,1'b0,1'b1,32'd100,32'd5,1'b0, 1'b1,1'b0,1'b1,2'b10,16'd0, 1'b0,1'b0,1'b0,{32'd100,32'd5});
      vecs[12] = mk(1'b1,1'b0,1'b1,32'd100,32'd7,1'b0, 1'b1,1'b0,1'b1,2'b10,16'd0, 1'b0,1'b0,1'b0,{32'd100,32'd5});
      vecs[13] = mk(1'b1,1'b1,1'b0,32'd0,  32'd0,1'b0, 1'b1,1'b0,1'b1,2'b10,16'd0, 1'b0,1'b0,1'b0,{32'd100,32'd5});
      // T3: store to a forbidden address
      vecs[14] = mk(1'b0,1'b0,1'b0,32'd0,  32'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd0, 1'b1,1'b0,1'b0,64'd0);
      vecs[15] = mk(1'b1,1'b1,1'b0,32'd0,  32'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd0, 1'b1,1'b0,1'b0,64'd0);
      vecs[16] = mk(1'b1,1'b0,1'b0,32'd0,  32'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd1, 1'b1,1'b0,1'b0,64'd0);
      vecs[17] = mk(1'b1,1'b0,1'b1,32'd64, 32'd1,1'b0, 1'b1,1'b0,1'b1,2'b01,16'd1, 1'b0,1'b0,1'b0,{32'd64,32'd1});
      // T5: fill, overflow, pop+push while full, reset mid-RUN
      vecs[18] = mk(1'b0,1'b0,1'b0,32'd0,  32'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd0, 1'b1,1'b0,1'b0,64'd0);
      vecs[19] = mk(1'b1,1'b1,1'b0,32'd0,  32'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd0, 1'b1,1'b0,1'b0,64'd0);
      vecs[20] = mk(1'b1,1'b0,1'b1,32'd96, 32'd1,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd1, 1'b0,1'b0,1'b0,{32'd96,32'd1});
      vecs[21] = mk(1'b1,1'b0,1'b1,32'd96, 32'd2,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd2, 1'b0,1'b1,1'b0,{32'd96,32'd1});
      vecs[22] = mk(1'b1,1'b0,1'b1,32'd96, 32'd3,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd3, 1'b0,1'b1,1'b1,{32'd96,32'd1});
      vecs[23] = mk(1'b1,1'b0,1'b1,32'd96, 32'd4,1'b1, 1'b0,1'b0,1'b0,2'b00,16'd4, 1'b0,1'b1,1'b1,{32'd96,32'd2});
      vecs[24] = mk(1'b1,1'b0,1'b0,32'd0,  32'd0,1'b1, 1'b0,1'b0,1'b0,2'b00,16'd5, 1'b0,1'b0,1'b1,{32'd96,32'd4});
      vecs[25] = mk(1'b0,1'b1,1'b1,32'd96, 32'd5,1'b1, 1'b0,1'b0,1'b0,2'b00,16'd0, 1'b1,1'b0,1'b0,64'd0);
      vecs[26] = mk(1'b1,1'b0,1'b0,32'd0,  32'd0,1'b0, 1'b0,1'b0,1'b0,2'b00,16'd0, 1'b1,1'b0,1'b0,64'd0);

      for (int i = 0; i < 27; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(vecs[i].rstN, vecs[i].en, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].rd);
         checkStatus(tag, vecs[i].expDone, vecs[i].expPass, vecs[i].expFail, vecs[i].expCode, vecs[i].expCycles);
`ifdef STORE_CHECKER_TRACE_EN
         check({tag, ".trace_empty"}, 64'(bus.trace_empty), 64'(vecs[i].expEmpty));
         check({tag, ".trace_full"},  64'(bus.trace_full),  64'(vecs[i].expFull));
         check({tag, ".trace_ovf"},   64'(bus.trace_ovf),   64'(vecs[i].expOvf));
         check({tag, ".trace_data"},  bus.trace_data,       vecs[i].expTrace);
`else
         check({tag, ".trace_empty"}, 64'(bus.trace_empty), 64'd1);
         check({tag, ".trace_full"},  64'(bus.trace_full),  64'd0);
         check({tag, ".trace_ovf"},   64'(bus.trace_ovf),   64'd0);
         check({tag, ".trace_data"},  bus.trace_data,       64'd0);
`endif
      end

      // T4a: plain timeout fires on the edge where cycles==19, then freezes
      runTo("t4a.pre", 19);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      checkStatus("t4a.timeout", 1'b1, 1'b0, 1'b1, 2'b11, 16'd19);
      drive(1'b1, 1'b1, 1'b1, 32'd100, 32'd7, 1'b0);
      checkStatus("t4a.frozen", 1'b1, 1'b0, 1'b1, 2'b11, 16'd19);

      // T4b: passing store on the timeout cycle wins
      runTo("t4b.pre", 19);
      drive(1'b1, 1'b0, 1'b1, 32'd100, 32'd7, 1'b0);
      checkStatus("t4b.pass", 1'b1, 1'b1, 1'b0, 2'b00, 16'd19);

      // T4c: an allowed store does not decide, so the timeout still fires
      runTo("t4c.pre", 19);
      drive(1'b1, 1'b0, 1'b1, 32'd96, 32'd9, 1'b0);
      checkStatus("t4c.timeout", 1'b1, 1'b0, 1'b1, 2'b11, 16'd19);

      // One cycle short of the timeout nothing happens
      runTo("t4d.pre", 18);
      drive(1'b1, 1'b0, 1'b1, 32'd96, 32'd9, 1'b0);
      checkStatus("t4d.run", 1'b0, 1'b0, 1'b0, 2'b00, 16'd19);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
